// File: rtl/ecap5_dproc_pkg.sv
// Shared definitions for the data-processor memory responder.
package ecap5_dproc_pkg;

  localparam int MEM_RESP_MAX_LATENCY = 4;
  localparam int MEM_RESP_MAX_STALL   = 7;
  localparam int MEM_RESP_CNT_W       = $clog2(MEM_RESP_MAX_STALL + 1);

  typedef enum logic {
    READY = 1'b0,
    HOLD  = 1'b1
  } mem_resp_state_t;

endpackage

// File: rtl/memory_responder_sram_be.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port,
// shaped so FPGA tools can map it onto block RAM.
module sram_be #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem [2**ADDR_BITS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int n = 0; n < 4; n++) begin
          if (be_i[n]) begin
            mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
          end
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Wishbone B4 pipelined slave backed by a byte-enabled RAM: fixed-latency acks
// and an optional stall window after every accepted request.
module memory_responder
  import ecap5_dproc_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int LATENCY      = 1,
  parameter int STALL_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o
);

  logic                      accept;
  logic [ADDR_BITS-1:0]      word_addr;
  logic [31:0]               ram_rdata;
  logic [31:0]               last_dat;
  logic                      unused_adr;

  logic [LATENCY-1:0]        vld_q, vld_d;
  logic [LATENCY-1:0]        rd_q, rd_d;

  mem_resp_state_t           state_q, state_d;
  logic [MEM_RESP_CNT_W-1:0] cnt_q, cnt_d;

  // A request landing on a reset edge is never accepted, so its write is dropped.
  assign accept     = rst_i && wb_cyc_i && wb_stb_i && !wb_stall_o;
  assign word_addr  = wb_adr_i[ADDR_BITS+1:2];
  assign unused_adr = ^{wb_adr_i[31:ADDR_BITS+2], wb_adr_i[1:0]};

  sram_be #(
    .ADDR_BITS(ADDR_BITS)
  ) u_sram (
    .clk_i  (clk_i),
    .en_i   (accept),
    .we_i   (wb_we_i),
    .be_i   (wb_sel_i),
    .addr_i (word_addr),
    .wdata_i(wb_dat_i),
    .rdata_o(ram_rdata)
  );

  // Stage 0: valid/read flags captured at the accept edge; later stages shift.
  always_comb begin
    vld_d    = vld_q;
    rd_d     = rd_q;
    vld_d[0] = accept;
    rd_d[0]  = !wb_we_i;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
    if (!wb_cyc_i) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    rd_q <= rd_d;
  end

  // The RAM output register is stage 0 data; deeper latencies add plain delay flops.
  if (LATENCY == 1) begin : g_dat_direct
    assign last_dat = ram_rdata;
  end else begin : g_dat_shift
    logic [LATENCY-2:0][31:0] dat_q, dat_d;

    always_comb begin
      dat_d    = dat_q;
      dat_d[0] = ram_rdata;
      for (int i = 1; i < LATENCY - 1; i++) begin
        dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      dat_q <= dat_d;
    end

    assign last_dat = dat_q[LATENCY-2];
  end

  assign wb_ack_o = vld_q[LATENCY-1];
  assign wb_dat_o = (wb_ack_o && rd_q[LATENCY-1]) ? last_dat : 32'h0;

  // Stall window: HOLD lasts exactly STALL_CYCLES cycles after each accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      READY: begin
        if (accept && (STALL_CYCLES > 0)) begin
          state_d = HOLD;
          cnt_d   = MEM_RESP_CNT_W'(STALL_CYCLES);
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == MEM_RESP_CNT_W'(1)) begin
          state_d = READY;
        end
      end
      default: begin
        state_d = READY;
      end
    endcase
    if (!wb_cyc_i) begin
      state_d = READY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_stall_o = (state_q == HOLD);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances (LATENCY=1, LATENCY=3, STALL_CYCLES=2)
// share one request bus and are selected by their own wb_cyc_i.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, wdat;
  logic        we, stb;
  logic [3:0]  sel;
  logic        cyc_a, cyc_b, cyc_c;
  logic [31:0] dat_a, dat_b, dat_c;
  logic        ack_a, ack_b, ack_c;
  logic        stall_a, stall_b, stall_c;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_BITS(10), .LATENCY(1), .STALL_CYCLES(0)) u_l1 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_a),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc_a),
    .wb_ack_o(ack_a), .wb_stall_o(stall_a)
  );

  memory_responder #(.ADDR_BITS(10), .LATENCY(3), .STALL_CYCLES(0)) u_l3 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_b),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc_b),
    .wb_ack_o(ack_b), .wb_stall_o(stall_b)
  );

  memory_responder #(.ADDR_BITS(10), .LATENCY(1), .STALL_CYCLES(2)) u_s2 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_c),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc_c),
    .wb_ack_o(ack_c), .wb_stall_o(stall_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    we   = w;
    adr  = a;
    wdat = d;
    sel  = s;
    stb  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc_a = 1'b1; cyc_b = 1'b1; cyc_c = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(i[0], $urandom, $urandom, 4'($urandom));
      tick();
      n_cmp++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack_a: got %b want 0", ack_a); end
      n_cmp++; if (dat_a !== 32'h0) begin n_fail++; $display("FAIL reset_dat_a: got %h want 0", dat_a); end
      n_cmp++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL reset_stall_a: got %b want 0", stall_a); end
      n_cmp++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL reset_ack_b: got %b want 0", ack_b); end
      n_cmp++; if (dat_b !== 32'h0) begin n_fail++; $display("FAIL reset_dat_b: got %h want 0", dat_b); end
      n_cmp++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL reset_stall_b: got %b want 0", stall_b); end
      n_cmp++; if (ack_c !== 1'b0) begin n_fail++; $display("FAIL reset_ack_c: got %b want 0", ack_c); end
      n_cmp++; if (dat_c !== 32'h0) begin n_fail++; $display("FAIL reset_dat_c: got %h want 0", dat_c); end
      n_cmp++; if (stall_c !== 1'b0) begin n_fail++; $display("FAIL reset_stall_c: got %b want 0", stall_c); end
    end
    rst_n = 1'b1;
    stb = 1'b0;
    cyc_a = 1'b0; cyc_b = 1'b0; cyc_c = 1'b0;
    tick();
  endtask

  task automatic test_full_word();
    cyc_a = 1'b1;
    drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tick();
    n_cmp++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL fw_write_ack: got %b want 1", ack_a); end
    n_cmp++; if (dat_a !== 32'h0) begin n_fail++; $display("FAIL fw_write_dat: got %h want 0", dat_a); end
    drive(1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    n_cmp++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL fw_read_ack: got %b want 1", ack_a); end
    n_cmp++; if (dat_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fw_read_dat: got %h want deadbeef", dat_a); end
    n_cmp++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL fw_stall: got %b want 0", stall_a); end
    stb = 1'b0;
    tick();
    n_cmp++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL fw_idle_ack: got %b want 0", ack_a); end
    n_cmp++; if (dat_a !== 32'h0) begin n_fail++; $display("FAIL fw_idle_dat: got %h want 0", dat_a); end
    cyc_a = 1'b0;
    tick();
  endtask

  task automatic test_byte_lanes();
    cyc_a = 1'b1;
    drive(1'b1, 32'h20, 32'h11223344, 4'hF);
    tick();
    drive(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    tick();
    drive(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    n_cmp++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL lanes_ack: got %b want 1", ack_a); end
    n_cmp++; if (dat_a !== 32'h11BB33DD) begin n_fail++; $display("FAIL lanes_dat: got %h want 11bb33dd", dat_a); end
    drive(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    tick();
    n_cmp++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL sel0_write_ack: got %b want 1", ack_a); end
    n_cmp++; if (dat_a !== 32'h0) begin n_fail++; $display("FAIL sel0_write_dat: got %h want 0", dat_a); end
    drive(1'b0, 32'h20, 32'h0, 4'hF);
    tick();
    n_cmp++; if (dat_a !== 32'h11BB33DD) begin n_fail++; $display("FAIL sel0_noop_dat: got %h want 11bb33dd", dat_a); end
    stb = 1'b0;
    tick();
    cyc_a = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    cyc_a = 1'b1;
    drive(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
    tick();
    stb = 1'b0;
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'hF);
    tick();
    n_cmp++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL wrap_ack: got %b want 1", ack_a); end
    n_cmp++; if (dat_a !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap_dat: got %h want cafef00d", dat_a); end
    drive(1'b0, 32'h3, 32'h0, 4'hF);
    tick();
    n_cmp++; if (dat_a !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lowbits_dat: got %h want cafef00d", dat_a); end
    stb = 1'b0;
    tick();
    cyc_a = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    cyc_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 32'(i + 1), 4'hF);
      tick();
    end
    stb = 1'b0;
    tick(); tick(); tick();
    drive(1'b0, 32'h0, 32'h0, 4'hF);
    tick();
    n_cmp++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_e0: got %b want 0", ack_b); end
    drive(1'b0, 32'h4, 32'h0, 4'hF);
    tick();
    n_cmp++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_e1: got %b want 0", ack_b); end
    n_cmp++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_e1: got %b want 0", stall_b); end
    drive(1'b0, 32'h8, 32'h0, 4'hF);
    tick();
    n_cmp++; if (ack_b !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_1: got %b want 1", ack_b); end
    n_cmp++; if (dat_b !== 32'd1) begin n_fail++; $display("FAIL b2b_dat_1: got %h want 1", dat_b); end
    stb = 1'b0;
    tick();
    n_cmp++; if (ack_b !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_2: got %b want 1", ack_b); end
    n_cmp++; if (dat_b !== 32'd2) begin n_fail++; $display("FAIL b2b_dat_2: got %h want 2", dat_b); end
    tick();
    n_cmp++; if (ack_b !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_3: got %b want 1", ack_b); end
    n_cmp++; if (dat_b !== 32'd3) begin n_fail++; $display("FAIL b2b_dat_3: got %h want 3", dat_b); end
    n_cmp++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_end: got %b want 0", stall_b); end
    tick();
    n_cmp++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_after: got %b want 0", ack_b); end
    n_cmp++; if (dat_b !== 32'h0) begin n_fail++; $display("FAIL b2b_dat_after: got %h want 0", dat_b); end
    cyc_b = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    cyc_b = 1'b1;
    drive(1'b0, 32'h4, 32'h0, 4'hF);
    tick();
    cyc_b = 1'b0;
    stb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL abort_ack[%0d]: got %b want 0", i, ack_b); end
      n_cmp++; if (dat_b !== 32'h0) begin n_fail++; $display("FAIL abort_dat[%0d]: got %h want 0", i, dat_b); end
    end
    cyc_b = 1'b1;
    drive(1'b0, 32'h8, 32'h0, 4'hF);
    tick();
    stb = 1'b0;
    tick(); tick();
    n_cmp++; if (ack_b !== 1'b1) begin n_fail++; $display("FAIL abort_recover_ack: got %b want 1", ack_b); end
    n_cmp++; if (dat_b !== 32'd3) begin n_fail++; $display("FAIL abort_recover_dat: got %h want 3", dat_b); end
    tick();
    n_cmp++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL abort_recover_once: got %b want 0", ack_b); end
    cyc_b = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    cyc_b = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'hF);
    tick();
    stb = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack[%0d]: got %b want 0", i, ack_b); end
      tick();
    end
    cyc_b = 1'b0;
    cyc_a = 1'b1;
    drive(1'b1, 32'h30, 32'h12345678, 4'hF);
    tick();
    stb = 1'b0;
    tick();
    drive(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_write_ack: got %b want 0", ack_a); end
    drive(1'b0, 32'h30, 32'h0, 4'hF);
    tick();
    n_cmp++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_read_ack: got %b want 1", ack_a); end
    n_cmp++; if (dat_a !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_read_dat: got %h want 12345678", dat_a); end
    stb = 1'b0;
    tick();
    cyc_a = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int   acks;
    logic exp_stall, exp_ack;
    acks = 0;
    cyc_c = 1'b1;
    for (int idx = 0; idx < 15; idx++) begin
      if (idx < 12) drive(1'b1, 32'((idx / 3) * 4), 32'h100 + 32'(idx / 3), 4'hF);
      else stb = 1'b0;
      exp_stall = (idx < 12) && (idx % 3 != 0);
      exp_ack   = (idx >= 1) && (idx <= 10) && (idx % 3 == 1);
      n_cmp++; if (stall_c !== exp_stall) begin n_fail++; $display("FAIL stall_pattern[%0d]: got %b want %b", idx, stall_c, exp_stall); end
      n_cmp++; if (ack_c !== exp_ack) begin n_fail++; $display("FAIL stall_ack[%0d]: got %b want %b", idx, ack_c, exp_ack); end
      if (ack_c === 1'b1) acks++;
      tick();
    end
    n_cmp++; if (acks !== 4) begin n_fail++; $display("FAIL stall_ack_count: got %0d want 4", acks); end
    drive(1'b0, 32'h8, 32'h0, 4'hF);
    tick();
    n_cmp++; if (ack_c !== 1'b1) begin n_fail++; $display("FAIL stall_read_ack: got %b want 1", ack_c); end
    n_cmp++; if (dat_c !== 32'h102) begin n_fail++; $display("FAIL stall_read_dat: got %h want 102", dat_c); end
    n_cmp++; if (stall_c !== 1'b1) begin n_fail++; $display("FAIL stall_after_read: got %b want 1", stall_c); end
    cyc_c = 1'b0;
    stb = 1'b0;
    tick();
    n_cmp++; if (stall_c !== 1'b0) begin n_fail++; $display("FAIL stall_cyc_drop: got %b want 0", stall_c); end
    n_cmp++; if (ack_c !== 1'b0) begin n_fail++; $display("FAIL stall_cyc_drop_ack: got %b want 0", ack_c); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    adr = '0; wdat = '0; we = 1'b0; sel = '0; stb = 1'b0;
    cyc_a = 1'b0; cyc_b = 1'b0; cyc_c = 1'b0;
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
